cost_monitor: RTL and testbench

COST_MONITOR -- requirements
Module: cost_monitor

---
 rtl/cost_monitor.sv | 112 +++++++++++
 tb/tb_cost_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cost_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cost_monitor: windowed mean-|cost| tracker with convergence and timeout detection.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cost_monitor #(
   parameter int WIDTH     = 24,
   parameter int LOG2_WIN  = 3,
   parameter int MAX_EPOCH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_cost,
   input  logic [WIDTH-1:0] i_threshold,
   output logic [WIDTH-1:0] o_avg,
   output logic             o_avg_valid,
   output logic [15:0]      o_epoch,
   output logic             o_busy,
   output logic             o_converged,
   output logic             o_timeout
);

   localparam int ACC_W = WIDTH + LOG2_WIN;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [LOG2_WIN-1:0] cnt;
   logic [WIDTH-1:0]    mag;
   logic [WIDTH-1:0]    avg_new;
   logic [15:0]         epoch_inc;
   logic                start_run;
   logic                take;
   logic                win_done;
   logic                conv_hit;
   logic                tmo_hit;

   // The most negative sample has no positive counterpart, so it clips.
   always_comb begin
      mag = i_cost;
      if (i_cost[WIDTH-1]) begin
         if (i_cost == MOST_NEG) mag = MOST_POS;
         else                    mag = -i_cost;
      end
   end

   assign acc_sum   = acc + {{LOG2_WIN{1'b0}}, mag};
   assign avg_new   = acc_sum[ACC_W-1:LOG2_WIN];
   assign epoch_inc = o_epoch + 16'd1;
   assign start_run = (state != ACCUM) && i_start;
   assign take      = (state == ACCUM) && i_valid;
   assign win_done  = take && (cnt == {LOG2_WIN{1'b1}});
   assign conv_hit  = win_done && (avg_new <= i_threshold);
   assign tmo_hit   = win_done && !conv_hit && (epoch_inc == 16'(MAX_EPOCH));
   assign o_busy    = (state == ACCUM);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_start) state_next = ACCUM;
         ACCUM:   if (conv_hit || tmo_hit) state_next = DONE;
         DONE:    if (i_start) state_next = ACCUM;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         o_avg       <= '0;
         o_avg_valid <= 1'b0;
         o_epoch     <= '0;
         o_converged <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         state       <= state_next;
         o_avg_valid <= win_done;
         if (start_run) begin
            acc         <= '0;
            cnt         <= '0;
            o_epoch     <= '0;
            o_converged <= 1'b0;
            o_timeout   <= 1'b0;
         end else if (win_done) begin
            o_avg       <= avg_new;
            o_epoch     <= epoch_inc;
            acc         <= '0;
            cnt         <= '0;
            o_converged <= conv_hit;
            o_timeout   <= tmo_hit;
         end else if (take) begin
            acc <= acc_sum;
            cnt <= cnt + LOG2_WIN'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cost_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cost_monitor: directed window table plus reset, gap and DONE-hold sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cost_monitor;

   localparam int W = 24;

   logic          clk;
   logic          rst;
   logic          start;
   logic          valid;
   logic [W-1:0]  cost;
   logic [W-1:0]  thr;
   logic [W-1:0]  avg;
   logic          avg_valid;
   logic [15:0]   epoch;
   logic          busy;
   logic          conv;
   logic          tmo;

   int total  = 0;
   int passed = 0;

   cost_monitor #(.WIDTH(W), .LOG2_WIN(3), .MAX_EPOCH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_valid     (valid),
      .i_cost      (cost),
      .i_threshold (thr),
      .o_avg       (avg),
      .o_avg_valid (avg_valid),
      .o_epoch     (epoch),
      .o_busy      (busy),
      .o_converged (conv),
      .o_timeout   (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            st;
      logic [W-1:0]    th;
      logic [7:0][W-1:0] c;
      logic [W-1:0]    e_avg;
      logic [15:0]     e_epoch;
      logic            e_busy;
      logic            e_conv;
      logic            e_tmo;
   } win_t;

   win_t tbl [14];

   function automatic logic [7:0][W-1:0] rep(input int v);
      logic [W-1:0] x;
      x = W'(v);
      return {8{x}};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      else passed++;
   endtask

   task automatic step(input logic s, input logic v, input logic [W-1:0] c);
      @(negedge clk);
      start = s;
      valid = v;
      cost  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_avg"}, 64'(avg), 0);
      chk({nm, "_avg_valid"}, 64'(avg_valid), 0);
      chk({nm, "_epoch"}, 64'(epoch), 0);
      chk({nm, "_busy"}, 64'(busy), 0);
      chk({nm, "_conv"}, 64'(conv), 0);
      chk({nm, "_tmo"}, 64'(tmo), 0);
   endtask

   task automatic run_window(input win_t w);
      thr = w.th;
      if (w.st) begin
         step(1'b1, 1'b0, '0);
         chk("start_busy", 64'(busy), 1);
         chk("start_epoch", 64'(epoch), 0);
         chk("start_conv", 64'(conv), 0);
         chk("start_tmo", 64'(tmo), 0);
      end
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, w.c[k]);
         chk("avg_valid_pulse", 64'(avg_valid), (k == 7) ? 1 : 0);
      end
      chk("win_avg", 64'(w.e_avg) ^ 64'(avg) ^ 64'(w.e_avg), 64'(w.e_avg));
      chk("win_epoch", 64'(epoch), 64'(w.e_epoch));
      chk("win_busy", 64'(busy), 64'(w.e_busy));
      chk("win_conv", 64'(conv), 64'(w.e_conv));
      chk("win_tmo", 64'(tmo), 64'(w.e_tmo));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; valid = 1'b0; cost = '0; thr = '0;

      tbl[0]  = '{1'b1, 24'd50, rep(100), 24'd100, 16'd1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 24'd50, rep(-40), 24'd40, 16'd2, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 24'hFFFFFF, rep(-8388608), 24'd8388607, 16'd1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 24'd7, {24'd8, {7{24'd7}}}, 24'd7, 16'd1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 24'd10, rep(1000), 24'd1000, 16'd1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 24'd10, rep(1000), 24'd1000, 16'd2, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 24'd10, rep(1000), 24'd1000, 16'd3, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 24'd10, rep(1000), 24'd1000, 16'd4, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 24'd10, {W'(-81), 24'd70, W'(-60), 24'd50, W'(-40), 24'd30, W'(-20), 24'd10},
                  24'd45, 16'd1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 24'd10, rep(9), 24'd9, 16'd2, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 24'd10, rep(1000), 24'd1000, 16'd1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 24'd10, rep(1000), 24'd1000, 16'd2, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 24'd10, rep(1000), 24'd1000, 16'd3, 1'b1, 1'b0, 1'b0};
      // Last allowed window also meets the threshold: convergence must win.
      tbl[13] = '{1'b0, 24'd10, rep(10), 24'd10, 16'd4, 1'b0, 1'b1, 1'b0};

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) run_window(tbl[i]);

      // Samples in DONE must not disturb held results.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 24'd500);
         chk("done_no_pulse", 64'(avg_valid), 0);
      end
      chk("done_avg", 64'(avg), 10);
      chk("done_epoch", 64'(epoch), 4);
      chk("done_conv", 64'(conv), 1);
      chk("done_busy", 64'(busy), 0);

      // Random gaps with i_start held high while accumulating.
      thr = '0;
      step(1'b1, 1'b0, '0);
      for (int k = 0; k < 8; k++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            step(1'b1, 1'b0, 24'd999);
            chk("gap_no_pulse", 64'(avg_valid), 0);
         end
         step(1'b0, 1'b1, W'(k + 1));
         chk("gap_pulse", 64'(avg_valid), (k == 7) ? 1 : 0);
      end
      chk("gap_avg", 64'(avg), 4);
      chk("gap_epoch", 64'(epoch), 1);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 24'd2);
         chk("b2b_pulse", 64'(avg_valid), (k == 7) ? 1 : 0);
      end
      chk("b2b_avg", 64'(avg), 2);
      chk("b2b_epoch", 64'(epoch), 2);
      chk("b2b_busy", 64'(busy), 1);

      // Asynchronous reset five samples into a window.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 24'd100);
      @(negedge clk);
      valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 24'd50);
         chk("idle_busy", 64'(busy), 0);
         chk("idle_no_pulse", 64'(avg_valid), 0);
      end
      step(1'b1, 1'b0, '0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 24'd16);
         chk("restart_pulse", 64'(avg_valid), (k == 7) ? 1 : 0);
      end
      chk("restart_avg", 64'(avg), 16);
      chk("restart_epoch", 64'(epoch), 1);
      step(1'b0, 1'b0, '0);
      chk("restart_pulse_end", 64'(avg_valid), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
